// File: rtl/uio_lite_master.sv
// AXI4-Lite master that issues single-word write/read commands to the UIO control-register slave.
// One transaction in flight; completion reported by a one-cycle response pulse.
module uio_lite_master #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             M_AXI_ACLK,
  input  logic             M_AXI_ARESETN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  output logic             rsp_write,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_resp,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] done_cnt,
  output logic [31:0]      M_AXI_AWADDR,
  output logic             M_AXI_AWVALID,
  input  logic             M_AXI_AWREADY,
  output logic [31:0]      M_AXI_WDATA,
  output logic [3:0]       M_AXI_WSTRB,
  output logic             M_AXI_WVALID,
  input  logic             M_AXI_WREADY,
  input  logic [1:0]       M_AXI_BRESP,
  input  logic             M_AXI_BVALID,
  output logic             M_AXI_BREADY,
  output logic [31:0]      M_AXI_ARADDR,
  output logic             M_AXI_ARVALID,
  input  logic             M_AXI_ARREADY,
  input  logic [31:0]      M_AXI_RDATA,
  input  logic [1:0]       M_AXI_RRESP,
  input  logic             M_AXI_RVALID,
  output logic             M_AXI_RREADY
);

  typedef enum logic [2:0] {StIdle, StWr, StWb, StRa, StRd} state_e;

  state_e           state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]       rsp_resp_q, rsp_resp_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [31:0]      wd_q, wd_d;
  logic             aw_fin, w_fin;

  // Word-aligned addressing: the byte-lane bits never reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr[1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    done_cnt_d  = done_cnt_q;
    aw_fin      = aw_done_q | (awvalid_q & M_AXI_AWREADY);
    w_fin       = w_done_q | (wvalid_q & M_AXI_WREADY);
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr[31:2];
          wdata_d = cmd_wdata;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRa;
          end
        end
      end
      StWr: begin
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = StWb;
        end
      end
      StWb: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_write_d = 1'b1;
          rsp_valid_d = 1'b1;
          done_cnt_d  = done_cnt_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      StRa: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRd;
        end
      end
      StRd: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          done_cnt_d  = done_cnt_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog only flags a stall; the transaction keeps waiting for its handshake.
    if ((state_d != state_q) || (state_q == StIdle)) begin
      wd_d = '0;
    end else if (wd_q != TIMEOUT) begin
      wd_d = wd_q + 32'd1;
    end else begin
      wd_d = wd_q;
    end
    timeout_d = timeout_q | ((TIMEOUT != 0) && (state_q != StIdle) && (wd_d == TIMEOUT));
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      timeout_q   <= 1'b0;
      done_cnt_q  <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
      done_cnt_q  <= done_cnt_d;
      wd_q        <= wd_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign timeout_err   = timeout_q;
  assign done_cnt      = done_cnt_q;
  assign M_AXI_AWADDR  = {addr_q, 2'b00};
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hf;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = {addr_q, 2'b00};
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
